// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, request owner, and the owner-to-wait-state mapping.
package mem_arb_pkg;

    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    function automatic arb_state_e wait_state(input arb_owner_e owner);
        return (owner == OWN_I) ? ARB_WAIT_I : ARB_WAIT_D;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side handshake bundle; slave = arbiter view, master = surrounding pipeline/memory view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_flush;
    logic                  i_resp_valid;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_we;
    logic [MASK_W-1:0]     d_wmask;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [MASK_W-1:0]     mem_wmask;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_req_valid, i_addr, i_flush,
        output i_req_ready, i_resp_valid, i_rdata,
        input  d_req_valid, d_addr, d_we, d_wmask, d_wdata,
        output d_req_ready, d_resp_valid, d_rdata,
        output mem_req_valid, mem_addr, mem_we, mem_wmask, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output i_req_valid, i_addr, i_flush,
        input  i_req_ready, i_resp_valid, i_rdata,
        output d_req_valid, d_addr, d_we, d_wmask, d_wdata,
        input  d_req_ready, d_resp_valid, d_rdata,
        input  mem_req_valid, mem_addr, mem_we, mem_wmask, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch (I) and data (D). Fixed D priority with starvation guard by default;
// round-robin on contention when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    input  logic       d_req_valid,
    input  logic       i_flush,
    input  logic       handshake,
    output arb_owner_e winner
);

    logic i_eligible_s;

    assign i_eligible_s = i_req_valid & ~i_flush;

`ifdef MEM_ARB_ROUND_ROBIN_EN

    arb_owner_e last_grant_q;

    // Contention goes to whoever did not win the previous grant.
    always_comb begin
        winner = OWN_D;
        if (i_eligible_s && d_req_valid) begin
            winner = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
        end else if (i_eligible_s) begin
            winner = OWN_I;
        end else begin
            winner = OWN_D;
        end
    end

    // Remember the owner of every accepted request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= OWN_I;
        end else if (handshake) begin
            last_grant_q <= winner;
        end else begin
            last_grant_q <= last_grant_q;
        end
    end

`else

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved_s;

    assign starved_s = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // D has priority unless I has been passed over STARVE_MAX times in a row.
    always_comb begin
        winner = OWN_D;
        if (i_eligible_s && (!d_req_valid || starved_s)) begin
            winner = OWN_I;
        end else begin
            winner = OWN_D;
        end
    end

    // Count D grants that happen while I is waiting; any idle I cycle or I grant clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req_valid) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (handshake && (winner == OWN_I)) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (handshake && !starved_s) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access; one transaction in flight, responses routed to
// the issuer, flushed fetch responses dropped. Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    arb_state_e state_q;
    logic       drop_q;
    logic       store_q;
    arb_owner_e winner_s;
    logic       i_eligible_s;
    logic       handshake_s;

    assign i_eligible_s = bus.i_req_valid & ~bus.i_flush;
    assign handshake_s  = bus.mem_req_valid & bus.mem_req_ready;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (bus.i_req_valid),
        .d_req_valid (bus.d_req_valid),
        .i_flush     (bus.i_flush),
        .handshake   (handshake_s),
        .winner      (winner_s)
    );

    // Request steering in IDLE and response pass-through in WAIT_x; everything is forced low in reset.
    always_comb begin
        bus.i_req_ready   = 1'b0;
        bus.i_resp_valid  = 1'b0;
        bus.i_rdata       = {DATA_WIDTH{1'b0}};
        bus.d_req_ready   = 1'b0;
        bus.d_resp_valid  = 1'b0;
        bus.d_rdata       = {DATA_WIDTH{1'b0}};
        bus.mem_req_valid = 1'b0;
        bus.mem_addr      = {ADDR_WIDTH{1'b0}};
        bus.mem_we        = 1'b0;
        bus.mem_wmask     = {MASK_W{1'b0}};
        bus.mem_wdata     = {DATA_WIDTH{1'b0}};
        if (rst) begin
            case (state_q)
                ARB_IDLE: begin
                    if ((winner_s == OWN_I) && i_eligible_s) begin
                        bus.mem_req_valid = 1'b1;
                        bus.mem_addr      = bus.i_addr;
                        bus.i_req_ready   = bus.mem_req_ready;
                    end else if ((winner_s == OWN_D) && bus.d_req_valid) begin
                        bus.mem_req_valid = 1'b1;
                        bus.mem_addr      = bus.d_addr;
                        bus.mem_we        = bus.d_we;
                        bus.mem_wmask     = bus.d_wmask;
                        bus.mem_wdata     = bus.d_wdata;
                        bus.d_req_ready   = bus.mem_req_ready;
                    end else begin
                        bus.mem_req_valid = 1'b0;
                    end
                end
                ARB_WAIT_I: begin
                    if (bus.mem_resp_valid && !drop_q && !bus.i_flush) begin
                        bus.i_resp_valid = 1'b1;
                        bus.i_rdata      = bus.mem_rdata;
                    end else begin
                        bus.i_resp_valid = 1'b0;
                    end
                end
                ARB_WAIT_D: begin
                    if (bus.mem_resp_valid) begin
                        bus.d_resp_valid = 1'b1;
                        bus.d_rdata      = store_q ? {DATA_WIDTH{1'b0}} : bus.mem_rdata;
                    end else begin
                        bus.d_resp_valid = 1'b0;
                    end
                end
                default: begin
                    bus.mem_req_valid = 1'b0;
                end
            endcase
        end else begin
            bus.mem_req_valid = 1'b0;
        end
    end

    // Transaction FSM; drop_q remembers a flush seen while a fetch was outstanding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            drop_q  <= 1'b0;
            store_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    drop_q <= 1'b0;
                    if (handshake_s) begin
                        state_q <= wait_state(winner_s);
                        store_q <= (winner_s == OWN_D) & bus.d_we;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_WAIT_I: begin
                    if (bus.mem_resp_valid) begin
                        state_q <= ARB_IDLE;
                        drop_q  <= 1'b0;
                    end else if (bus.i_flush) begin
                        drop_q  <= 1'b1;
                    end else begin
                        drop_q  <= drop_q;
                    end
                end
                ARB_WAIT_D: begin
                    if (bus.mem_resp_valid) begin
                        state_q <= ARB_IDLE;
                    end else begin
                        state_q <= ARB_WAIT_D;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    drop_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants/responses are queued by the stimulus and
// checked by an independent negedge monitor.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        arb_owner_e  owner;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        arb_owner_e  owner;
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic rst;

    req_t        exp_req_q[$];
    resp_t       exp_resp_q[$];
    logic [31:0] mem_data_q[$];

    int   n_tests;
    int   n_fail;
    logic done;
    logic hs_seen;
    int   cd;
    int   resp_delay;
    bit   auto_resp;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic exp_grant(input arb_owner_e o, input logic [31:0] a, input logic we,
                             input logic [3:0] m, input logic [31:0] wd);
        exp_req_q.push_back('{owner: o, addr: a, we: we, wmask: m, wdata: wd});
    endtask

    task automatic exp_rsp(input arb_owner_e o, input logic [31:0] mem_val, input logic [31:0] exp_val);
        mem_data_q.push_back(mem_val);
        exp_resp_q.push_back('{owner: o, data: exp_val});
    endtask

    // Advance one cycle; model a memory answering resp_delay cycles after each accepted request.
    task automatic tick();
        logic hs;
        @(posedge clk);
        hs = hs_seen;
        #1;
        if (cd > 0) cd--;
        if (hs && auto_resp) cd = resp_delay;
        if (cd == 1 && mem_data_q.size() > 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = mem_data_q.pop_front();
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = 32'h0;
        end
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        int cyc;
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        hs_seen = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            hs_seen = bus.mem_req_valid & bus.mem_req_ready;
            if (!rst) begin
                n_tests++;
                if ({bus.i_req_ready, bus.i_resp_valid, bus.i_rdata, bus.d_req_ready, bus.d_resp_valid,
                     bus.d_rdata, bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wmask,
                     bus.mem_wdata} != 138'h0) begin
                    n_fail++;
                    $display("FAIL reset_outputs: cycle %0d outputs not all zero (mem_req_valid=%b addr=%h rdy=%b%b)",
                             cyc, bus.mem_req_valid, bus.mem_addr, bus.i_req_ready, bus.d_req_ready);
                end
            end else begin
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    n_tests++;
                    if (exp_req_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_grant: cycle %0d addr=%h rdy=%b%b, none expected",
                                 cyc, bus.mem_addr, bus.i_req_ready, bus.d_req_ready);
                    end else begin
                        req_t e;
                        logic ok;
                        e  = exp_req_q.pop_front();
                        ok = ({bus.i_req_ready, bus.d_req_ready} == ((e.owner == OWN_I) ? 2'b10 : 2'b01))
                             && (bus.mem_addr == e.addr) && (bus.mem_we == e.we)
                             && ((e.owner == OWN_I) || ((bus.mem_wmask == e.wmask) && (bus.mem_wdata == e.wdata)));
                        if (!ok) begin
                            n_fail++;
                            $display("FAIL grant: cycle %0d got rdy(i,d)=%b%b addr=%h we=%b mask=%b wdata=%h; want owner=%s addr=%h we=%b mask=%b wdata=%h",
                                     cyc, bus.i_req_ready, bus.d_req_ready, bus.mem_addr, bus.mem_we,
                                     bus.mem_wmask, bus.mem_wdata, e.owner.name(), e.addr, e.we, e.wmask, e.wdata);
                        end
                    end
                end else if (bus.mem_req_valid) begin
                    n_tests++;
                    if (bus.i_req_ready || bus.d_req_ready) begin
                        n_fail++;
                        $display("FAIL stall_ready: cycle %0d rdy(i,d)=%b%b while memory not ready, want 00",
                                 cyc, bus.i_req_ready, bus.d_req_ready);
                    end
                end
                if (bus.i_resp_valid || bus.d_resp_valid) begin
                    n_tests++;
                    if (exp_resp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_resp: cycle %0d valid(i,d)=%b%b i_rdata=%h d_rdata=%h, none expected",
                                 cyc, bus.i_resp_valid, bus.d_resp_valid, bus.i_rdata, bus.d_rdata);
                    end else begin
                        resp_t r;
                        logic [31:0] got;
                        r   = exp_resp_q.pop_front();
                        got = (r.owner == OWN_I) ? bus.i_rdata : bus.d_rdata;
                        if (({bus.i_resp_valid, bus.d_resp_valid} != ((r.owner == OWN_I) ? 2'b10 : 2'b01))
                            || (got != r.data)) begin
                            n_fail++;
                            $display("FAIL resp: cycle %0d got valid(i,d)=%b%b data=%h; want owner=%s data=%h",
                                     cyc, bus.i_resp_valid, bus.d_resp_valid, got, r.owner.name(), r.data);
                        end
                    end
                end
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", cyc);
        end
        n_tests++;
        if (exp_req_q.size() != 0 || exp_resp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d grants and %0d responses never seen, want 0 and 0",
                     exp_req_q.size(), exp_resp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Directed stimulus.
    initial begin : stim
        arb_owner_e seq [10];
        done               = 1'b0;
        cd                 = 0;
        resp_delay         = 1;
        auto_resp          = 1'b1;
        rst                = 1'b0;
        bus.i_req_valid    = 1'b1;
        bus.i_addr         = 32'h0000_0AAA;
        bus.i_flush        = 1'b0;
        bus.d_req_valid    = 1'b1;
        bus.d_addr         = 32'h0000_0BBB;
        bus.d_we           = 1'b1;
        bus.d_wmask        = 4'b1111;
        bus.d_wdata        = 32'hFFFF_FFFF;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hFFFF_FFFF;

        // Reset with all inputs active: every output must stay 0.
        repeat (3) begin
            tick();
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = 32'hFFFF_FFFF;
        end
        tick();
        rst             = 1'b1;
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        bus.d_we        = 1'b0;
        bus.d_wmask     = 4'b0000;
        bus.d_wdata     = 32'h0;

        // I only, one stall cycle then accepted; response one cycle later.
        tick();
        bus.i_req_valid   = 1'b1;
        bus.i_addr        = 32'h1C00_0000;
        bus.mem_req_ready = 1'b0;
        tick();
        bus.mem_req_ready = 1'b1;
        exp_grant(OWN_I, 32'h1C00_0000, 1'b0, 4'b0000, 32'h0);
        exp_rsp(OWN_I, 32'h0280_0404, 32'h0280_0404);
        tick();
        bus.i_req_valid = 1'b0;
        tick();

        // Store with partial mask: memory data ignored, store ack returns 0; flush in WAIT_D is harmless.
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h0000_0100;
        bus.d_we        = 1'b1;
        bus.d_wmask     = 4'b0011;
        bus.d_wdata     = 32'hDEAD_BEEF;
        exp_grant(OWN_D, 32'h0000_0100, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        exp_rsp(OWN_D, 32'h55AA_55AA, 32'h0);
        tick();
        bus.d_req_valid = 1'b0;
        bus.d_we        = 1'b0;
        bus.d_wmask     = 4'b0000;
        bus.d_wdata     = 32'h0;
        bus.i_flush     = 1'b1;
        tick();
        bus.i_flush     = 1'b0;
        // Load returns memory data.
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h0000_0104;
        exp_grant(OWN_D, 32'h0000_0104, 1'b0, 4'b0000, 32'h0);
        exp_rsp(OWN_D, 32'h1122_3344, 32'h1122_3344);
        tick();
        bus.d_req_valid = 1'b0;
        tick();

        // Fetch flushed while outstanding: late response dropped.
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h0000_0040;
        resp_delay      = 3;
        exp_grant(OWN_I, 32'h0000_0040, 1'b0, 4'b0000, 32'h0);
        mem_data_q.push_back(32'h0000_1234);
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_flush     = 1'b1;
        tick();
        bus.i_flush     = 1'b0;
        tick();
        tick();
        // Flush in IDLE suppresses the I request.
        bus.i_req_valid = 1'b1;
        bus.i_flush     = 1'b1;
        bus.i_addr      = 32'h0000_0080;
        resp_delay      = 1;
        tick();
        bus.i_flush     = 1'b0;
        exp_grant(OWN_I, 32'h0000_0080, 1'b0, 4'b0000, 32'h0);
        exp_rsp(OWN_I, 32'hCAFE_0080, 32'hCAFE_0080);
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        // Flush coinciding with the response cycle also drops it.
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h0000_00C0;
        exp_grant(OWN_I, 32'h0000_00C0, 1'b0, 4'b0000, 32'h0);
        mem_data_q.push_back(32'h0BAD_F00D);
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_flush     = 1'b1;
        tick();
        bus.i_flush     = 1'b0;

        // Reset during WAIT_D, stray response right after release must be ignored.
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h0000_0500;
        auto_resp       = 1'b0;
        exp_grant(OWN_D, 32'h0000_0500, 1'b0, 4'b0000, 32'h0);
        tick();
        bus.d_req_valid = 1'b0;
        rst             = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h0000_0777;
        tick();
        tick();
        rst                = 1'b1;
        bus.i_req_valid    = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0BAD_0BAD;
        tick();
        auto_resp       = 1'b1;
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h0000_0600;
        exp_grant(OWN_I, 32'h0000_0600, 1'b0, 4'b0000, 32'h0);
        exp_rsp(OWN_I, 32'h0060_0600, 32'h0060_0600);
        tick();
        bus.i_req_valid = 1'b0;
        tick();

        // Both held continuously for ten grants.
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            seq[k] = (k % 2 == 0) ? OWN_D : OWN_I;
`else
            seq[k] = (k == 4 || k == 9) ? OWN_I : OWN_D;
`endif
        end
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h0000_0300;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h0000_0200;
        for (int k = 0; k < 10; k++) begin
            exp_grant(seq[k], (seq[k] == OWN_I) ? 32'h0000_0300 : 32'h0000_0200, 1'b0, 4'b0000, 32'h0);
            exp_rsp(seq[k], 32'hA000_0000 + 32'(k), 32'hA000_0000 + 32'(k));
        end
        repeat (19) tick();
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;

        repeat (3) tick();
        done = 1'b1;
    end

endmodule
